// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel rotator register: default width and
// the derivation of the rotate-amount width from the word width.
package barrel_pkg;

    localparam int unsigned DATA_SIZE = 8;

    function automatic int unsigned sel_width_of(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/barrel_rotl.sv
// Combinational rotate-left: log2(data_size) cascaded mux stages, amount
// bit k selecting a rotate by 2^k positions.
module barrel_rotl
    import barrel_pkg::*;
#(
    parameter int unsigned data_size = DATA_SIZE,
    parameter int unsigned sel_width = sel_width_of(data_size)
) (
    input  logic [data_size-1:0] din,
    input  logic [sel_width-1:0] amt,
    output logic [data_size-1:0] dout
);

    logic [sel_width:0][data_size-1:0] stage;

    assign stage[0] = din;

    for (genvar k = 0; k < sel_width; k++) begin : g_stage
        localparam int unsigned SH = 1 << k;
        logic [data_size-1:0] rotated;
        // Upper SH bits wrap around into the low end.
        assign rotated      = {stage[k][data_size-1-SH:0], stage[k][data_size-1:data_size-SH]};
        assign stage[k+1]   = amt[k] ? rotated : stage[k];
    end

    assign dout = stage[sel_width];

endmodule

// File: rtl/barrel_2.sv
// Recirculating barrel rotator register: loads a word, then rotates it left
// by sel positions every clock while Load is low.
module barrel_2
    import barrel_pkg::*;
#(
    parameter int unsigned data_size = DATA_SIZE,
    parameter int unsigned sel_width = sel_width_of(data_size)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Load,
    input  logic [sel_width-1:0] sel,
    input  logic [data_size-1:0] data_in,
    output logic [data_size-1:0] data_out
);

    logic [data_size-1:0] r;
    logic [data_size-1:0] rotated;

    barrel_rotl #(
        .data_size (data_size),
        .sel_width (sel_width)
    ) u_rotl (
        .din  (r),
        .amt  (sel),
        .dout (rotated)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r <= '0;
        end else begin
            r <= Load ? data_in : rotated;
        end
    end

    assign data_out = r;

endmodule

// File: tb/tb_barrel_2.sv
// Directed test of barrel_2 with hand-computed expected register contents.
module tb_barrel_2;

    logic       clk;
    logic       reset;
    logic       Load;
    logic [2:0] sel;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int unsigned checks;
    int unsigned failures;

    barrel_2 #(
        .data_size (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Load     (Load),
        .sel      (sel),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (data_out === exp)
        else begin
            failures++;
            $error("FAIL %s: data_out=%h expected=%h", tag, data_out, exp);
        end
    endtask

    logic [7:0] walk_exp  [8];
    logic [7:0] sweep_exp [8];

    initial begin
        checks   = 0;
        failures = 0;
        walk_exp  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        sweep_exp = '{8'h01, 8'h02, 8'h08, 8'h40, 8'h04, 8'h80, 8'h20, 8'h10};

        reset   = 1'b0;
        Load    = 1'b0;
        sel     = 3'd0;
        data_in = 8'h00;
        #1;
        check("reset_initial", 8'h00);

        // Load A5, then assert reset between edges
        #10;
        reset = 1'b1;
        do_step();
        Load    = 1'b1;
        data_in = 8'hA5;
        do_step();
        check("load_a5", 8'hA5);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", 8'h00);
        #1;
        reset = 1'b1;
        Load  = 1'b0;
        sel   = 3'd1;
        do_step();
        check("rotate_zero", 8'h00);

        // Load with unknown sel, then hold with sel=0
        Load    = 1'b1;
        data_in = 8'h02;
        sel     = 3'bxxx;
        do_step();
        check("load_sel_x", 8'h02);
        Load = 1'b0;
        sel  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            do_step();
            check("hold_sel0", 8'h02);
        end

        // Single-step walk with wrap
        Load    = 1'b1;
        data_in = 8'h01;
        do_step();
        check("load_01", 8'h01);
        Load = 1'b0;
        sel  = 3'd1;
        for (int i = 0; i < 8; i++) begin
            do_step();
            check("walk_sel1", walk_exp[i]);
        end

        // Multi-bit rotates
        Load    = 1'b1;
        data_in = 8'h81;
        do_step();
        Load = 1'b0;
        sel  = 3'd3;
        do_step();
        check("rot3_a", 8'h0C);
        do_step();
        check("rot3_b", 8'h60);
        do_step();
        check("rot3_c", 8'h03);
        Load    = 1'b1;
        data_in = 8'hB4;
        do_step();
        Load = 1'b0;
        sel  = 3'd7;
        do_step();
        check("rot7", 8'h5A);

        // Cumulative sel sweep, then Load priority
        Load    = 1'b1;
        data_in = 8'h01;
        do_step();
        Load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            do_step();
            check("sweep", sweep_exp[i]);
        end
        Load    = 1'b1;
        sel     = 3'd5;
        data_in = 8'h33;
        do_step();
        check("load_priority", 8'h33);

        // Reset during rotation
        data_in = 8'h0F;
        do_step();
        Load = 1'b0;
        sel  = 3'd2;
        do_step();
        check("rot2_a", 8'h3C);
        do_step();
        check("rot2_b", 8'hF0);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid", 8'h00);
        do_step();
        check("reset_held", 8'h00);
        #2;
        reset   = 1'b1;
        Load    = 1'b1;
        data_in = 8'h0F;
        do_step();
        check("reload_0f", 8'h0F);
        Load = 1'b0;
        do_step();
        check("resume_rot2", 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/barrel_2.md
# barrel_2

Recirculating barrel rotator register for the enhanced processor datapath. It loads a `data_size`-bit word, then rotates the stored word left by `sel` bit positions on every clock edge while `Load` is low. The stored word is always visible on `data_out`. It serves as the shift/rotate resource for the processor's ALU-side operand path.

## Interface
- `data_size`, default 8: word width; must be a power of two, at least 2.
- `sel_width`, default log2(`data_size`) (3): width of `sel`. Derived from `data_size`; not overridden independently.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Clears the register immediately on assertion; release takes effect at the next rising edge.
- `Load` input 1: when 1, capture `data_in`; when 0, rotate the stored word.
- `sel` input `sel_width`: rotate-left amount, 0 to `data_size`-1, applied per clock while `Load`=0.
- `data_in` input `data_size`: parallel load word.
- `data_out` output `data_size`: current register contents, driven directly from the flops.

## Operation
- One state register R, `data_size` bits wide; `data_out` = R at all times.
- `reset`=0: R = 0 asynchronously, regardless of `clk`, `Load` or `sel`.
- Rising `clk`, `reset`=1, `Load`=1: R ← `data_in`. `sel` is ignored, including X/unknown values.
- Rising `clk`, `reset`=1, `Load`=0: R ← rotl(R, `sel`), with bit i of the result = R[(i − `sel`) mod `data_size`].
- `sel`=0 holds R unchanged.
- The rotation is circular: no bits are lost and no zero fill occurs. Shifting past the MSB wraps to the LSB.
- Rotation amounts are cumulative across cycles, taken modulo `data_size`.
- `Load` has priority over rotation; there is no other control input.
- No output flags, no handshake; the block is always ready.

## Timing
- Reset value: `data_out` = 0, visible immediately on `reset` falling, with no clock needed.
- Load latency: 1 cycle. `data_in` sampled at edge N appears on `data_out` after edge N.
- Rotate latency: 1 cycle per rotation step.
- `sel` and `data_in` must be stable around the rising edge. They are sampled only at the edge, with no combinational path to `data_out`.
- Reset asserted mid-rotation: R goes to 0 immediately and stays 0 until the first edge after release.
- First edge after release: the normal Load/rotate rule applies. Rotating 0 yields 0.
- Rotator logic is combinational, built as log2(`data_size`) mux stages of 1, 2, 4, … positions. It must close timing in one cycle.

## Structure
- Shared package `barrel_pkg`:
  - Default `DATA_SIZE` = 8.
  - Function computing `sel_width` as clog2 of `data_size`.
- One sub-module, `barrel_rotl`: purely combinational.
  - Inputs: `din[data_size]`, `amt[sel_width]`.
  - Output: `dout` = rotl(`din`, `amt`).
  - Implemented as cascaded power-of-two mux stages, amount bit k selecting a rotate of 2^k.
- Top level holds:
  - the register;
  - the Load/rotate 2:1 mux feeding the register;
  - the async active-low reset.

## Test plan
- Reset: drive `reset`=0 with `data_out` previously 8'hA5 → `data_out`=8'h00 immediately without a clock edge. Release, then `Load`=0, `sel`=1 → `data_out` stays 8'h00.
- Load/hold: `Load`=1, `data_in`=8'h02, `sel`=X → `data_out`=8'h02 after 1 edge. Then `Load`=0, `sel`=0 for 5 edges → `data_out` stays 8'h02.
- Single-step wrap: load 8'h01, then `sel`=1 for 8 edges → 02, 04, 08, 10, 20, 40, 80, 01.
- Multi-bit rotate: load 8'h81, then `sel`=3 for 3 edges → 0C, 60, 03. Load 8'hB4, then one edge with `sel`=7 → 8'h5A.
- Load priority and sel sweep: load 8'h01, then `sel`=0..7 one per edge → cumulative rotations 0, 1, 3, 6, 10, 15, 21, 28 (mod 8 = 0, 1, 3, 6, 2, 7, 5, 4), giving 01, 02, 08, 40, 04, 80, 20, 10. Assert `Load`=1 with `sel`=5, `data_in`=8'h33 → 8'h33, not rotated.
- Reset mid-operation: while rotating 8'h0F with `sel`=2, drop `reset` between edges → 8'h00 at once. Release and load 8'h0F → normal operation resumes with 8'h0F.
